// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU op codes, multiplier FSM states.
// No logic; latency n/a; backpressure n/a.
// Multiplier-related items are only referenced when EX_MUL_EN is defined.
package ex_pkg;

    localparam int XLEN    = 32;
    localparam int RD_W    = 5;
    localparam int MUL_CYC = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier returning the low XLEN bits of a*b.
// Latency: start edge + MUL_CYC step edges, done is high for the following cycle.
// Backpressure: none; the caller must not start while busy is high.
module ex_mul_seq
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam logic [4:0] CNT_LAST = 5'(MUL_CYC - 1);

    mul_state_t      state;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc;
    logic [4:0]      cnt;

    assign product = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (b_q[0]) acc <= acc + a_q;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // busy stays up through this cycle so the stage cannot accept while the result lands
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, branch target/compare, load/store address, EX/MEM register; multiplier only with EX_MUL_EN.
// Latency: 1 cycle for all ops; MUL takes 33 edges from accept when EX_MUL_EN is defined.
// Backpressure: in_ready drops while the output register is stalled or the multiplier is busy.
module execute_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic            use_imm,
    input  logic            is_branch,
    input  logic            is_mem,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    input  logic [XLEN-1:0] br_se,
    input  logic [XLEN-1:0] ls_se,
    input  logic [XLEN-1:0] alu_se,
    input  logic [RD_W-1:0] rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] br_target,
    output logic            br_taken,
    output logic [RD_W-1:0] rd_out,
    output logic            busy
);

    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] br_tgt;
    logic            accept;
    logic            mul_start;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    assign in_ready = !mul_busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = mul_busy;
    assign br_tgt   = pc_in + (br_se << 2);

    always_comb begin
        opb     = use_imm ? alu_se : dataB;
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = dataA + opb;
            ALU_SUB:  alu_res = dataA - opb;
            ALU_AND:  alu_res = dataA & opb;
            ALU_OR:   alu_res = dataA | opb;
            ALU_XOR:  alu_res = dataA ^ opb;
            ALU_SLL:  alu_res = dataA << opb[4:0];
            ALU_SRL:  alu_res = dataA >> opb[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(dataA) >>> opb[4:0]);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(dataA) < $signed(opb)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, dataA < opb};
            default:  alu_res = '0;
        endcase
        if (is_branch) begin
            alu_res = '0;
        end else if (is_mem) begin
            alu_res = dataA + ls_se;
        end
    end

`ifdef EX_MUL_EN
    assign mul_start = accept && (alu_op == ALU_MUL) && !is_mem && !is_branch;

    ex_mul_seq u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (dataA),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign mul_start = 1'b0;
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            store_data <= '0;
            br_target  <= '0;
            br_taken   <= 1'b0;
            rd_out     <= '0;
        end else if (mul_done) begin
            result    <= mul_prod;
            out_valid <= 1'b1;
        end else if (accept) begin
            // a MUL accept stages its side fields now; result and valid arrive with mul_done
            result     <= alu_res;
            store_data <= dataB;
            br_target  <= br_tgt;
            br_taken   <= is_branch && (dataA == dataB);
            rd_out     <= rd_in;
            out_valid  <= !mul_start;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expectations, a negedge monitor checks pops.
// MUL expectations follow whether EX_MUL_EN is defined for the build.
module tb_execute_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  alu_op;
    logic        use_imm, is_branch, is_mem;
    logic [31:0] pc_in, dataA, dataB, br_se, ls_se, alu_se;
    logic [4:0]  rd_in;
    logic        out_valid, out_ready;
    logic [31:0] result, store_data, br_target;
    logic        br_taken;
    logic [4:0]  rd_out;
    logic        busy;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .use_imm(use_imm), .is_branch(is_branch), .is_mem(is_mem),
        .pc_in(pc_in), .dataA(dataA), .dataB(dataB), .br_se(br_se), .ls_se(ls_se),
        .alu_se(alu_se), .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .store_data(store_data), .br_target(br_target),
        .br_taken(br_taken), .rd_out(rd_out), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic        tkn;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic imm, input logic br, input logic mem,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] bse, input logic [31:0] lse, input logic [31:0] ase,
                        input logic [4:0] rd, input logic [31:0] eres, input logic [31:0] etgt,
                        input logic etkn);
        int   n;
        exp_t e;
        alu_op = op; use_imm = imm; is_branch = br; is_mem = mem;
        pc_in = pc; dataA = a; dataB = b; br_se = bse; ls_se = lse; alu_se = ase;
        rd_in = rd; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready=0 required=1");
            in_valid = 1'b0;
            return;
        end
        e.res = eres; e.sd = b; e.tgt = etgt; e.tkn = etkn; e.rd = rd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: a pop happens on the next rising edge whenever out_valid && out_ready here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_output: result=%h required=no output", result);
            end else begin
                m_e = sb_q.pop_front();
                chk("result", result, m_e.res);
                chk("store_data", store_data, m_e.sd);
                chk("br_target", br_target, m_e.tgt);
                chk("br_taken", 32'(br_taken), 32'(m_e.tkn));
                chk("rd_out", 32'(rd_out), 32'(m_e.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 4'd0; use_imm = 1'b0; is_branch = 1'b0; is_mem = 1'b0;
        pc_in = '0; dataA = '0; dataB = '0; br_se = '0; ls_se = '0; alu_se = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 5'd3,
             32'd12, 32'h0, 1'b0);
        chk("add_latency_out_valid", 32'(out_valid), 32'd1);
        chk("add_rd_direct", 32'(rd_out), 32'd3);

        send(ALU_SUB,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 5'd4,
             32'hFFFF_FFFF, 32'h0, 1'b0);
        send(ALU_SLT,  1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'd5,
             32'h1, 32'h0, 1'b0);
        send(ALU_SLTU, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 5'd6,
             32'h0, 32'h0, 1'b0);
        send(ALU_SRA,  1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 32'h0, 5'd7,
             32'hF800_0000, 32'h0, 1'b0);
        send(ALU_SRL,  1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 32'h4, 32'h0, 32'h0, 32'h0, 5'd8,
             32'h0800_0000, 32'h0, 1'b0);
        send(ALU_SLL,  1'b0, 1'b0, 1'b0, 32'h0, 32'h1, 32'h21, 32'h0, 32'h0, 32'h0, 5'd9,
             32'h2, 32'h0, 1'b0);
        send(ALU_AND,  1'b0, 1'b0, 1'b0, 32'h0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 5'd10,
             32'hF000, 32'h0, 1'b0);
        send(ALU_OR,   1'b0, 1'b0, 1'b0, 32'h0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 5'd11,
             32'hFFF0, 32'h0, 1'b0);
        send(ALU_XOR,  1'b0, 1'b0, 1'b0, 32'h0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0, 5'd12,
             32'h0FF0, 32'h0, 1'b0);
        send(ALU_ADD,  1'b1, 1'b0, 1'b0, 32'h0, 32'd10, 32'h55, 32'h0, 32'h0, 32'hFFFF_FFFE, 5'd13,
             32'd8, 32'h0, 1'b0);
        send(4'd12,    1'b0, 1'b0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 5'd14,
             32'h0, 32'h0, 1'b0);
        send(ALU_SUB,  1'b0, 1'b0, 1'b1, 32'h0, 32'h1000, 32'hDEAD, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd15,
             32'h0FFC, 32'h0, 1'b0);

        send(ALU_ADD,  1'b0, 1'b1, 1'b0, 32'h100, 32'd9, 32'd9, 32'hFFFF_FFFE, 32'h0, 32'h0, 5'd0,
             32'h0, 32'hF8, 1'b1);
        send(ALU_ADD,  1'b0, 1'b1, 1'b0, 32'h100, 32'd9, 32'd8, 32'hFFFF_FFFE, 32'h0, 32'h0, 5'd0,
             32'h0, 32'hF8, 1'b0);

        // Backpressure: let the branch result drain, then stall the output register.
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'h0, 32'd20, 32'd22, 32'h0, 32'h0, 32'h0, 5'd7,
             32'd42, 32'h0, 1'b0);
        alu_op = ALU_SUB; dataA = 32'd50; dataB = 32'd8; rd_in = 5'd9; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold_result", result, 32'd42);
            chk("stall_hold_rd", 32'(rd_out), 32'd7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(ALU_SUB, 1'b0, 1'b0, 1'b0, 32'h0, 32'd50, 32'd8, 32'h0, 32'h0, 32'h0, 5'd9,
             32'd42, 32'h0, 1'b0);
        chk("pop_accept_out_valid", 32'(out_valid), 32'd1);
        chk("pop_accept_result", result, 32'd42);

`ifdef EX_MUL_EN
        begin
            int   bc;
            logic saw_ready;
            bc = 0;
            saw_ready = 1'b0;
            send(ALU_MUL, 1'b0, 1'b0, 1'b0, 32'h0, 32'd3, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd10,
                 32'hFFFF_FFFD, 32'h0, 1'b0);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!busy) break;
                bc++;
                if (in_ready) saw_ready = 1'b1;
            end
            chk("mul_busy_cycles", bc, 32'd33);
            chk("mul_in_ready_low", 32'(saw_ready), 32'd0);
            chk("mul_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        send(ALU_MUL, 1'b0, 1'b0, 1'b0, 32'h0, 32'd6, 32'd7, 32'h0, 32'h0, 32'h0, 5'd11,
             32'd42, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        chk("mid_mul_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_rd_out", 32'(rd_out), 32'd0);
        chk("mid_rst_store_data", store_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'h0, 32'd1, 32'd2, 32'h0, 32'h0, 32'h0, 5'd12,
             32'd3, 32'h0, 1'b0);
        begin
            logic late;
            late = 1'b0;
            @(negedge clk);
            repeat (40) begin
                @(negedge clk);
                if (out_valid || busy) late = 1'b1;
            end
            chk("mul_discarded_after_reset", 32'(late), 32'd0);
        end
`else
        begin
            logic rose;
            rose = 1'b0;
            send(ALU_MUL, 1'b0, 1'b0, 1'b0, 32'h0, 32'd3, 32'd4, 32'h0, 32'h0, 32'h0, 5'd10,
                 32'h0, 32'h0, 1'b0);
            chk("nomul_latency", 32'(out_valid), 32'd1);
            repeat (5) begin
                @(negedge clk);
                if (busy) rose = 1'b1;
            end
            chk("nomul_busy_never", 32'(rose), 32'd0);
        end
`endif

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
